// File: rtl/uart_pkg.sv
// Shared definitions for the UART APB controller: register map, STATUS layout,
// transmit sequencer state encoding and the default slave-select code.
package uart_pkg;

  localparam logic [1:0] UART_SEL_DEFAULT = 2'b10;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_VALID    = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_TX_OVERFLOW = 4;
  localparam int ST_TX_BUSY     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } tx_state_e;

  function automatic logic [31:0] pack_status(
    input logic tx_full,
    input logic tx_empty,
    input logic rx_valid,
    input logic rx_overrun,
    input logic tx_overflow,
    input logic tx_busy
  );
    logic [31:0] s;
    s = '0;
    s[ST_TX_FULL]     = tx_full;
    s[ST_TX_EMPTY]    = tx_empty;
    s[ST_RX_VALID]    = rx_valid;
    s[ST_RX_OVERRUN]  = rx_overrun;
    s[ST_TX_OVERFLOW] = tx_overflow;
    s[ST_TX_BUSY]     = tx_busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO for transmit data. Pointers carry one extra MSB so
// full and empty are distinguished without a separate count.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB register front end for the UART: TX byte FIFO with a one-frame-at-a-time
// start/done sequencer, and an RX holding register with valid/overrun tracking.
module uart_apb_ctrl
  import uart_pkg::*;
#(
  parameter int         TX_DEPTH = 4,
  parameter logic [1:0] UART_SEL = UART_SEL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  psel,
  input  logic        pen,
  input  logic        pwr,
  input  logic [31:0] pAdd,
  input  logic [31:0] pwData,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        txDone,
  output logic        rxStart,
  input  logic [7:0]  rxData,
  input  logic        rxDone
);

  tx_state_e   tx_state;
  logic        tx_en;
  logic        rx_en;
  logic [7:0]  rx_hold;
  logic        rx_valid;
  logic        rx_overrun;
  logic        tx_overflow;

  logic        access;
  logic        apb_wr;
  logic        apb_rd;
  logic [1:0]  reg_sel;
  logic        tx_push;
  logic        tx_pop;
  logic        rx_pop;
  logic        status_wr;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] status_word;
  logic        unused_bits;

  assign unused_bits = ^{pAdd[31:4], pAdd[1:0], pwData[31:8]};

  assign access    = (psel == UART_SEL) && pen;
  assign pready    = access;
  assign apb_wr    = access && pwr;
  assign apb_rd    = access && !pwr;
  assign reg_sel   = pAdd[3:2];
  assign tx_push   = apb_wr && (reg_sel == REG_TXDATA);
  assign status_wr = apb_wr && (reg_sel == REG_STATUS);
  assign rx_pop    = apb_rd && (reg_sel == REG_RXDATA) && rx_valid;
  assign tx_pop    = (tx_state == LOAD);
  assign rxStart   = rx_en;

  uart_tx_fifo #(
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tx_push),
    .push_data(pwData[7:0]),
    .pop      (tx_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign status_word = pack_status(fifo_full, fifo_empty, rx_valid, rx_overrun,
                                   tx_overflow, tx_state != IDLE);

  always_comb begin
    prdata = '0;
    if (apb_rd) begin
      case (reg_sel)
        REG_RXDATA: prdata = {24'h0, rx_hold};
        REG_STATUS: prdata = status_word;
        REG_CTRL:   prdata = {30'h0, rx_en, tx_en};
        default:    prdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_en <= 1'b0;
      rx_en <= 1'b0;
    end else if (apb_wr && (reg_sel == REG_CTRL)) begin
      tx_en <= pwData[0];
      rx_en <= pwData[1];
    end
  end

  // txData is captured on entry to LOAD so it is already stable when txStart rises;
  // the FIFO slot itself is released at the end of LOAD.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_state <= IDLE;
      txStart  <= 1'b0;
      txData   <= 8'h00;
    end else begin
      case (tx_state)
        IDLE: begin
          txStart <= 1'b0;
          if (tx_en && !fifo_empty) begin
            tx_state <= LOAD;
            txStart  <= 1'b1;
            txData   <= fifo_head;
          end
        end
        LOAD: begin
          tx_state <= WAIT;
          txStart  <= 1'b0;
        end
        WAIT: begin
          txStart <= 1'b0;
          if (txDone) tx_state <= IDLE;
        end
        default: begin
          tx_state <= IDLE;
          txStart  <= 1'b0;
        end
      endcase
    end
  end

  // A new byte arriving while the previous one is still unread overwrites it and
  // flags overrun, unless the old byte is being read out in the same cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_hold    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rxDone) begin
        rx_hold  <= rxData;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
      if (rxDone && rx_valid && !rx_pop)
        rx_overrun <= 1'b1;
      else if (status_wr && pwData[ST_RX_OVERRUN])
        rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_overflow <= 1'b0;
    end else if (tx_push && fifo_full && !tx_pop) begin
      tx_overflow <= 1'b1;
    end else if (status_wr && pwData[ST_TX_OVERFLOW]) begin
      tx_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Directed self-checking bench for uart_apb_ctrl: APB register access, TX
// sequencing and FIFO overflow, RX capture/overrun, and reset mid-frame.
module tb_uart_apb_ctrl;

  localparam logic [1:0] SEL = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  psel;
  logic        pen;
  logic        pwr;
  logic [31:0] pAdd;
  logic [31:0] pwData;
  logic [31:0] prdata;
  logic        pready;
  logic        txStart;
  logic [7:0]  txData;
  logic        txDone;
  logic        rxStart;
  logic [7:0]  rxData;
  logic        rxDone;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] cap_q[$];

  uart_apb_ctrl #(
    .TX_DEPTH(4),
    .UART_SEL(SEL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .psel   (psel),
    .pen    (pen),
    .pwr    (pwr),
    .pAdd   (pAdd),
    .pwData (pwData),
    .prdata (prdata),
    .pready (pready),
    .txStart(txStart),
    .txData (txData),
    .txDone (txDone),
    .rxStart(rxStart),
    .rxData (rxData),
    .rxDone (rxDone)
  );

  always #5 clk = ~clk;

  // Record the byte presented with every start pulse.
  always @(negedge clk) begin
    if (txStart === 1'b1) cap_q.push_back(txData);
  end

  task automatic apb_write(input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    psel = SEL; pen = 1'b0; pwr = 1'b1;
    pAdd = {28'h1234_567, r, 2'b00}; pwData = d;
    @(negedge clk);
    pen = 1'b1;
    @(negedge clk);
    psel = 2'b00; pen = 1'b0; pwr = 1'b0; pwData = '0;
  endtask

  task automatic apb_read(input logic [1:0] r, output logic [31:0] d, output logic rdy);
    @(negedge clk);
    psel = SEL; pen = 1'b0; pwr = 1'b0;
    pAdd = {28'h1234_567, r, 2'b00};
    @(negedge clk);
    pen = 1'b1;
    #1;
    d = prdata; rdy = pready;
    @(negedge clk);
    psel = 2'b00; pen = 1'b0;
  endtask

  task automatic pulse_txdone();
    @(negedge clk); txDone = 1'b1;
    @(negedge clk); txDone = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(negedge clk); rxDone = 1'b1; rxData = b;
    @(negedge clk); rxDone = 1'b0;
  endtask

  task automatic wait_starts(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cap_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic rdy;
    rst_n = 1'b1;
    #1;
    tests_run++; if (prdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_prdata got %h want %h", prdata, 32'h0); end
    tests_run++; if (pready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pready got %b want 0", pready); end
    tests_run++; if (txStart !== 1'b0 || txData !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_tx got %b/%h want 0/00", txStart, txData); end
    tests_run++; if (rxStart !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rxstart got %b want 0", rxStart); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h2) begin tests_failed++; $display("[TB] FAIL reset_status got %h want %h", d, 32'h2); end
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL pready_access got %b want 1", rdy); end
    // access with a foreign select code must be invisible
    @(negedge clk);
    psel = 2'b01; pen = 1'b1; pwr = 1'b1; pAdd = 32'hC; pwData = 32'h3;
    #1;
    tests_run++; if (pready !== 1'b0) begin tests_failed++; $display("[TB] FAIL foreign_pready got %b want 0", pready); end
    @(negedge clk);
    psel = 2'b00; pen = 1'b0; pwr = 1'b0;
    apb_read(2'd3, d, rdy);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("[TB] FAIL foreign_ctrl got %h want %h", d, 32'h0); end
  endtask

  task automatic test_single_tx();
    logic [31:0] d; logic rdy;
    apb_write(2'd3, 32'h1);
    cap_q.delete();
    apb_write(2'd0, 32'hFFFF_FFA5);
    tests_run++; if (txStart !== 1'b0) begin tests_failed++; $display("[TB] FAIL tx_early got %b want 0", txStart); end
    @(negedge clk);
    tests_run++; if (txStart !== 1'b1 || txData !== 8'hA5) begin tests_failed++; $display("[TB] FAIL tx_pulse got %b/%h want 1/a5", txStart, txData); end
    @(negedge clk);
    tests_run++; if (txStart !== 1'b0 || txData !== 8'hA5) begin tests_failed++; $display("[TB] FAIL tx_pulse_end got %b/%h want 0/a5", txStart, txData); end
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h22) begin tests_failed++; $display("[TB] FAIL tx_busy_status got %h want %h", d, 32'h22); end
    pulse_txdone();
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h02) begin tests_failed++; $display("[TB] FAIL tx_done_status got %h want %h", d, 32'h02); end
    tests_run++; if (cap_q.size() !== 1) begin tests_failed++; $display("[TB] FAIL tx_single_count got %0d want 1", cap_q.size()); end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic rdy; bit ok;
    cap_q.delete();
    for (int i = 1; i <= 5; i++) apb_write(2'd0, i);
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h21) begin tests_failed++; $display("[TB] FAIL fifo_full_status got %h want %h", d, 32'h21); end
    apb_write(2'd0, 32'h06);
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h31) begin tests_failed++; $display("[TB] FAIL overflow_status got %h want %h", d, 32'h31); end
    apb_write(2'd2, 32'h10);
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h21) begin tests_failed++; $display("[TB] FAIL overflow_w1c got %h want %h", d, 32'h21); end
    for (int n = 2; n <= 5; n++) begin
      pulse_txdone();
      wait_starts(n, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL drain_timeout got %0d starts want %0d", cap_q.size(), n); end
    end
    pulse_txdone();
    repeat (4) @(negedge clk);
    tests_run++; if (cap_q.size() !== 5) begin tests_failed++; $display("[TB] FAIL drain_count got %0d want 5", cap_q.size()); end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      tests_run++; if (cap_q[i] !== 8'(i + 1)) begin tests_failed++; $display("[TB] FAIL drain_order[%0d] got %h want %h", i, cap_q[i], 8'(i + 1)); end
    end
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h02) begin tests_failed++; $display("[TB] FAIL drain_status got %h want %h", d, 32'h02); end
  endtask

  task automatic test_rx();
    logic [31:0] d; logic rdy;
    apb_write(2'd3, 32'h3);
    tests_run++; if (rxStart !== 1'b1) begin tests_failed++; $display("[TB] FAIL rxstart got %b want 1", rxStart); end
    apb_read(2'd3, d, rdy);
    tests_run++; if (d !== 32'h3) begin tests_failed++; $display("[TB] FAIL ctrl_read got %h want %h", d, 32'h3); end
    pulse_rx(8'h3C);
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h06) begin tests_failed++; $display("[TB] FAIL rx_valid_status got %h want %h", d, 32'h06); end
    apb_read(2'd1, d, rdy);
    tests_run++; if (d !== 32'h3C) begin tests_failed++; $display("[TB] FAIL rx_data got %h want %h", d, 32'h3C); end
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h02) begin tests_failed++; $display("[TB] FAIL rx_popped_status got %h want %h", d, 32'h02); end
    apb_write(2'd1, 32'h77);
    apb_read(2'd1, d, rdy);
    tests_run++; if (d !== 32'h3C) begin tests_failed++; $display("[TB] FAIL rx_stale_read got %h want %h", d, 32'h3C); end
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h02) begin tests_failed++; $display("[TB] FAIL rx_stale_status got %h want %h", d, 32'h02); end
  endtask

  task automatic test_overrun();
    logic [31:0] d; logic rdy;
    pulse_rx(8'h11);
    pulse_rx(8'h22);
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h0E) begin tests_failed++; $display("[TB] FAIL overrun_status got %h want %h", d, 32'h0E); end
    apb_read(2'd1, d, rdy);
    tests_run++; if (d !== 32'h22) begin tests_failed++; $display("[TB] FAIL overrun_data got %h want %h", d, 32'h22); end
    apb_write(2'd2, 32'h08);
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h02) begin tests_failed++; $display("[TB] FAIL overrun_w1c got %h want %h", d, 32'h02); end
    pulse_rx(8'h44);
    @(negedge clk);
    psel = SEL; pen = 1'b0; pwr = 1'b0; pAdd = 32'h4;
    @(negedge clk);
    pen = 1'b1; rxDone = 1'b1; rxData = 8'h55;
    #1;
    tests_run++; if (prdata !== 32'h44) begin tests_failed++; $display("[TB] FAIL coincident_read got %h want %h", prdata, 32'h44); end
    @(negedge clk);
    psel = 2'b00; pen = 1'b0; rxDone = 1'b0;
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h06) begin tests_failed++; $display("[TB] FAIL coincident_status got %h want %h", d, 32'h06); end
    apb_read(2'd1, d, rdy);
    tests_run++; if (d !== 32'h55) begin tests_failed++; $display("[TB] FAIL coincident_data got %h want %h", d, 32'h55); end
  endtask

  task automatic test_tx_disable();
    logic [31:0] d; logic rdy; bit ok;
    cap_q.delete();
    apb_write(2'd0, 32'hA1);
    wait_starts(1, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL dis_first_timeout got %0d starts want 1", cap_q.size()); end
    apb_write(2'd0, 32'hA2);
    apb_write(2'd0, 32'hA3);
    apb_write(2'd3, 32'h2);
    pulse_txdone();
    repeat (8) @(negedge clk);
    tests_run++; if (cap_q.size() !== 1) begin tests_failed++; $display("[TB] FAIL dis_no_start got %0d starts want 1", cap_q.size()); end
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h00) begin tests_failed++; $display("[TB] FAIL dis_status got %h want %h", d, 32'h00); end
    apb_write(2'd3, 32'h3);
    wait_starts(2, ok);
    pulse_txdone();
    wait_starts(3, ok);
    pulse_txdone();
    repeat (4) @(negedge clk);
    tests_run++; if (cap_q.size() !== 3) begin tests_failed++; $display("[TB] FAIL dis_resume_count got %0d want 3", cap_q.size()); end
    if (cap_q.size() == 3) begin
      tests_run++; if (cap_q[0] !== 8'hA1 || cap_q[1] !== 8'hA2 || cap_q[2] !== 8'hA3) begin tests_failed++; $display("[TB] FAIL dis_order got %h %h %h want a1 a2 a3", cap_q[0], cap_q[1], cap_q[2]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d; logic rdy; bit ok;
    cap_q.delete();
    apb_write(2'd0, 32'hB1);
    wait_starts(1, ok);
    apb_write(2'd0, 32'hB2);
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h20) begin tests_failed++; $display("[TB] FAIL pre_reset_status got %h want %h", d, 32'h20); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++; if (txStart !== 1'b0 || txData !== 8'h00) begin tests_failed++; $display("[TB] FAIL mid_reset_tx got %b/%h want 0/00", txStart, txData); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    pulse_txdone();
    apb_read(2'd2, d, rdy);
    tests_run++; if (d !== 32'h02) begin tests_failed++; $display("[TB] FAIL post_reset_status got %h want %h", d, 32'h02); end
    cap_q.delete();
    apb_write(2'd3, 32'h1);
    repeat (8) @(negedge clk);
    tests_run++; if (cap_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL flushed_fifo got %0d starts want 0", cap_q.size()); end
  endtask

  initial begin
    rst_n = 1'b1; psel = 2'b00; pen = 1'b0; pwr = 1'b0;
    pAdd = '0; pwData = '0; txDone = 1'b0; rxData = 8'h00; rxDone = 1'b0;
    test_reset();
    test_single_tx();
    test_overflow();
    test_rx();
    test_overrun();
    test_tx_disable();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
